// File: rtl/mc_ctrl_if.sv
// Control/datapath boundary for the multi-cycle MIPS core.
// The master side (mc_ctrl) reads the decoded IR fields and the zero flag, and drives every enable and mux select.
// The slave side (datapath) is the mirror image of the master side.
interface mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             zero;
   logic             ir_we;
   logic             pc_we;
   logic [1:0]       npc_sel;
   logic             grf_we;
   logic [1:0]       a3_sel;
   logic [1:0]       wd_sel;
   logic             alu_src;
   logic [1:0]       ext_op;
   logic [2:0]       alu_op;
   logic             dm_we;
   logic [2:0]       state;
   logic [CNT_W-1:0] instr_cnt;

   modport master (
      input  opcode, funct, zero,
      output ir_we, pc_we, npc_sel, grf_we, a3_sel, wd_sel,
             alu_src, ext_op, alu_op, dm_we, state, instr_cnt
   );

   modport slave (
      output opcode, funct, zero,
      input  ir_we, pc_we, npc_sel, grf_we, a3_sel, wd_sel,
             alu_src, ext_op, alu_op, dm_we, state, instr_cnt
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/exec/mem/wb and drives datapath enables and selects.
// Latency: outputs are a combinational function of the registered state; 2-5 states per instruction, plus IM_WAIT cycles.
// No backpressure: the only stall is the fixed IM_WAIT fetch delay, and reset forces every write enable low.
module mc_ctrl #(
   parameter int IM_WAIT = 0,
   parameter int CNT_W   = 32
) (
   input logic       clk,
   input logic       reset,
   mc_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam logic [3:0] WAIT_LAST = 4'(IM_WAIT);

   state_t           state_q;
   logic [3:0]       wait_q;
   logic [CNT_W-1:0] cnt_q;

   logic is_r, is_sub, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, known;
   logic ir_we_raw, pc_we_raw, grf_we_raw, dm_we_raw;
   logic fetch_done;

   // Instruction class from the latched IR fields.
   always_comb begin
      is_r   = (bus.opcode == OP_RTYPE) && ((bus.funct == FN_ADDU) || (bus.funct == FN_SUBU));
      is_sub = (bus.funct == FN_SUBU);
      is_jr  = (bus.opcode == OP_RTYPE) && (bus.funct == FN_JR);
      is_ori = (bus.opcode == OP_ORI);
      is_lui = (bus.opcode == OP_LUI);
      is_lw  = (bus.opcode == OP_LW);
      is_sw  = (bus.opcode == OP_SW);
      is_beq = (bus.opcode == OP_BEQ);
      is_j   = (bus.opcode == OP_J);
      is_jal = (bus.opcode == OP_JAL);
      known  = is_r | is_jr | is_ori | is_lui | is_lw | is_sw | is_beq | is_j | is_jal;
   end

   assign fetch_done = (wait_q == WAIT_LAST);

   // Datapath controls per state; enables are collected raw and gated by reset below.
   always_comb begin
      ir_we_raw   = 1'b0;
      pc_we_raw   = 1'b0;
      grf_we_raw  = 1'b0;
      dm_we_raw   = 1'b0;
      bus.npc_sel = 2'b00;
      bus.a3_sel  = 2'b00;
      bus.wd_sel  = 2'b00;
      bus.alu_src = 1'b0;
      bus.ext_op  = 2'b00;
      bus.alu_op  = 3'b000;
      case (state_q)
         FETCH: begin
            ir_we_raw = fetch_done;
         end
         DECODE: begin
            if (is_j) begin
               pc_we_raw   = 1'b1;
               bus.npc_sel = 2'b10;
            end else if (is_jal) begin
               pc_we_raw   = 1'b1;
               bus.npc_sel = 2'b10;
               grf_we_raw  = 1'b1;
               bus.a3_sel  = 2'b10;
               bus.wd_sel  = 2'b10;
            end else if (is_jr) begin
               pc_we_raw   = 1'b1;
               bus.npc_sel = 2'b11;
            end else if (!known) begin
               // Unsupported encodings retire as a NOP straight from decode.
               pc_we_raw   = 1'b1;
               bus.npc_sel = 2'b00;
            end
         end
         EXEC: begin
            if (is_r) begin
               bus.alu_src = 1'b0;
               bus.alu_op  = is_sub ? 3'b001 : 3'b000;
            end else if (is_ori) begin
               bus.ext_op  = 2'b00;
               bus.alu_src = 1'b1;
               bus.alu_op  = 3'b010;
            end else if (is_lui) begin
               // imm<<16 OR'd with $0 yields the upper-immediate value.
               bus.ext_op  = 2'b10;
               bus.alu_src = 1'b1;
               bus.alu_op  = 3'b010;
            end else if (is_lw || is_sw) begin
               bus.ext_op  = 2'b01;
               bus.alu_src = 1'b1;
               bus.alu_op  = 3'b000;
            end else if (is_beq) begin
               bus.alu_op  = 3'b001;
               pc_we_raw   = 1'b1;
               bus.npc_sel = bus.zero ? 2'b01 : 2'b00;
            end
         end
         MEM: begin
            if (is_sw) begin
               dm_we_raw   = 1'b1;
               pc_we_raw   = 1'b1;
               bus.npc_sel = 2'b00;
            end
         end
         WB: begin
            grf_we_raw  = 1'b1;
            pc_we_raw   = 1'b1;
            bus.npc_sel = 2'b00;
            bus.a3_sel  = is_r ? 2'b01 : 2'b00;
            bus.wd_sel  = is_lw ? 2'b01 : 2'b00;
         end
         default: begin
         end
      endcase
   end

   // A reset cycle must never commit architectural state.
   assign bus.ir_we     = ir_we_raw & ~reset;
   assign bus.pc_we     = pc_we_raw & ~reset;
   assign bus.grf_we    = grf_we_raw & ~reset;
   assign bus.dm_we     = dm_we_raw & ~reset;
   assign bus.state     = state_q;
   assign bus.instr_cnt = cnt_q;

   // State sequencing, fetch wait counter and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         wait_q  <= 4'd0;
         cnt_q   <= '0;
      end else begin
         if (pc_we_raw) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         case (state_q)
            FETCH: begin
               if (fetch_done) begin
                  state_q <= DECODE;
                  wait_q  <= 4'd0;
               end else begin
                  wait_q  <= wait_q + 4'd1;
               end
            end
            DECODE: begin
               if (is_j || is_jal || is_jr || !known) state_q <= FETCH;
               else                                   state_q <= EXEC;
            end
            EXEC: begin
               if (is_beq)              state_q <= FETCH;
               else if (is_lw || is_sw) state_q <= MEM;
               else                     state_q <= WB;
            end
            MEM: begin
               if (is_sw) state_q <= FETCH;
               else       state_q <= WB;
            end
            WB: begin
               state_q <= FETCH;
            end
            default: begin
               state_q <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: two instances (IM_WAIT=0/CNT_W=4 and IM_WAIT=2/CNT_W=32).
// Each instruction is expanded by the bench into its expected cycle trace.
// Every cycle of that trace is checked against the DUT outputs.
module tb_mc_ctrl;

   localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
   localparam int K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_UNK = 10;

   typedef struct packed {
      logic        ir_we;
      logic        pc_we;
      logic        grf_we;
      logic        dm_we;
      logic [1:0]  npc_sel;
      logic [1:0]  a3_sel;
      logic [1:0]  wd_sel;
      logic        alu_src;
      logic [1:0]  ext_op;
      logic [2:0]  alu_op;
      logic [2:0]  state;
      logic [31:0] cnt;
   } obs_t;

   logic clk = 1'b0;
   logic rst0, rst2;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   mcnt0    = 0;
   int   mcnt2    = 0;

   always #5 clk = ~clk;

   mc_ctrl_if #(.CNT_W(4))  bus0 ();
   mc_ctrl_if #(.CNT_W(32)) bus2 ();

   mc_ctrl #(.IM_WAIT(0), .CNT_W(4))  dut0 (.clk(clk), .reset(rst0), .bus(bus0.master));
   mc_ctrl #(.IM_WAIT(2), .CNT_W(32)) dut2 (.clk(clk), .reset(rst2), .bus(bus2.master));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic obs_t get(input int sel);
      obs_t o;
      if (sel == 0) begin
         o = {bus0.ir_we, bus0.pc_we, bus0.grf_we, bus0.dm_we, bus0.npc_sel, bus0.a3_sel, bus0.wd_sel,
              bus0.alu_src, bus0.ext_op, bus0.alu_op, bus0.state, 28'd0, bus0.instr_cnt};
      end else begin
         o = {bus2.ir_we, bus2.pc_we, bus2.grf_we, bus2.dm_we, bus2.npc_sel, bus2.a3_sel, bus2.wd_sel,
              bus2.alu_src, bus2.ext_op, bus2.alu_op, bus2.state, bus2.instr_cnt};
      end
      return o;
   endfunction

   task automatic set_in(input int sel, input logic [5:0] op, input logic [5:0] fn, input logic z);
      if (sel == 0) begin
         bus0.opcode = op; bus0.funct = fn; bus0.zero = z;
      end else begin
         bus2.opcode = op; bus2.funct = fn; bus2.zero = z;
      end
   endtask

   task automatic set_rst(input int sel, input logic v);
      if (sel == 0) rst0 = v;
      else          rst2 = v;
   endtask

   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00: begin
            if (fn == 6'h21)      return K_ADDU;
            else if (fn == 6'h23) return K_SUBU;
            else if (fn == 6'h08) return K_JR;
            else                  return K_UNK;
         end
         6'h0D:   return K_ORI;
         6'h0F:   return K_LUI;
         6'h23:   return K_LW;
         6'h2B:   return K_SW;
         6'h04:   return K_BEQ;
         6'h02:   return K_J;
         6'h03:   return K_JAL;
         default: return K_UNK;
      endcase
   endfunction

   task automatic encode(input int k, output logic [5:0] op, output logic [5:0] fn);
      logic [5:0] rnd;
      rnd = 6'($urandom);
      fn  = rnd;
      case (k)
         K_ADDU: begin op = 6'h00; fn = 6'h21; end
         K_SUBU: begin op = 6'h00; fn = 6'h23; end
         K_JR:   begin op = 6'h00; fn = 6'h08; end
         K_ORI:  op = 6'h0D;
         K_LUI:  op = 6'h0F;
         K_LW:   op = 6'h23;
         K_SW:   op = 6'h2B;
         K_BEQ:  op = 6'h04;
         K_J:    op = 6'h02;
         K_JAL:  op = 6'h03;
         default: begin
            case ($urandom_range(0, 2))
               0:       begin op = 6'h3F; end
               1:       begin op = 6'h00; fn = 6'h2A; end
               default: begin op = 6'h08; end
            endcase
         end
      endcase
   endtask

   // Runs one instruction; abort_at >= 0 raises reset during that cycle of the trace.
   task automatic run(input int sel, input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int abort_at);
      int   w, k, total, cexp, mask;
      int   seq[$];
      bit   en, last_c, writes;
      obs_t o;
      w    = (sel == 0) ? 0 : 2;
      mask = (sel == 0) ? 15 : -1;
      k    = classify(op, fn);
      for (int i = 0; i <= w; i++) seq.push_back(0);
      seq.push_back(1);
      case (k)
         K_BEQ:                        seq.push_back(2);
         K_ADDU, K_SUBU, K_ORI, K_LUI: begin seq.push_back(2); seq.push_back(4); end
         K_SW:                         begin seq.push_back(2); seq.push_back(3); end
         K_LW:                         begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
         default: begin end
      endcase
      total  = seq.size();
      writes = (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI || k == K_LW || k == K_JAL);
      set_in(sel, op, fn, z);
      for (int c = 0; c < total; c++) begin
         en     = (c != abort_at);
         last_c = (c == total - 1);
         if (!en) set_rst(sel, 1'b1);
         @(negedge clk);
         o    = get(sel);
         cexp = ((sel == 0) ? mcnt0 : mcnt2) & mask;
         chk("state", 32'(o.state), 32'(seq[c]));
         chk("ir_we", 32'(o.ir_we), 32'(en && c == w));
         chk("pc_we", 32'(o.pc_we), 32'(en && last_c));
         chk("grf_we", 32'(o.grf_we), 32'(en && last_c && writes));
         chk("dm_we", 32'(o.dm_we), 32'(en && last_c && k == K_SW));
         chk("instr_cnt", o.cnt, cexp);
         if (en && last_c) begin
            chk("npc_sel", 32'(o.npc_sel),
                32'((k == K_J || k == K_JAL) ? 2 : (k == K_JR) ? 3 : (k == K_BEQ && z) ? 1 : 0));
            if (writes) begin
               chk("a3_sel", 32'(o.a3_sel), 32'((k == K_JAL) ? 2 : (k == K_ADDU || k == K_SUBU) ? 1 : 0));
               chk("wd_sel", 32'(o.wd_sel), 32'((k == K_JAL) ? 2 : (k == K_LW) ? 1 : 0));
            end
         end
         if (en && seq[c] == 2) begin
            chk("alu_op", 32'(o.alu_op),
                32'((k == K_SUBU || k == K_BEQ) ? 1 : (k == K_ORI || k == K_LUI) ? 2 : 0));
            if (k != K_BEQ) chk("alu_src", 32'(o.alu_src), 32'((k == K_ADDU || k == K_SUBU) ? 0 : 1));
            if (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW)
               chk("ext_op", 32'(o.ext_op), 32'((k == K_ORI) ? 0 : (k == K_LUI) ? 2 : 1));
         end
         @(posedge clk);
         #1;
         if (!en) begin
            o = get(sel);
            chk("abort_state", 32'(o.state), 32'd0);
            chk("abort_cnt", o.cnt, 32'd0);
            if (sel == 0) mcnt0 = 0; else mcnt2 = 0;
            set_rst(sel, 1'b0);
            return;
         end
         if (last_c) begin
            if (sel == 0) mcnt0++; else mcnt2++;
         end
      end
   endtask

   task automatic do_reset(input int sel, input int cycles);
      obs_t o;
      set_rst(sel, 1'b1);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         o = get(sel);
         chk("rst_enables", 32'({o.ir_we, o.pc_we, o.grf_we, o.dm_we}), 32'd0);
         if (i > 0) chk("rst_state", 32'(o.state), 32'd0);
         @(posedge clk);
         #1;
      end
      set_rst(sel, 1'b0);
      if (sel == 0) mcnt0 = 0; else mcnt2 = 0;
   endtask

   task automatic run_random(input int sel, input int n);
      logic [5:0] op, fn;
      for (int i = 0; i < n; i++) begin
         encode($urandom_range(0, 10), op, fn);
         run(sel, op, fn, 1'($urandom), -1);
      end
   endtask

   initial begin
      rst0 = 1'b1;
      rst2 = 1'b1;
      set_in(0, 6'h3F, 6'h00, 1'b0);
      set_in(1, 6'h3F, 6'h00, 1'b0);
      @(posedge clk);
      #1;

      do_reset(0, 3);
      run(0, 6'h00, 6'h21, 1'b0, -1);
      chk("cnt_after_addu", 32'(bus0.instr_cnt), 32'd1);
      run(0, 6'h23, 6'h00, 1'b0, -1);
      run(0, 6'h2B, 6'h00, 1'b0, -1);
      run(0, 6'h04, 6'h00, 1'b1, -1);
      run(0, 6'h04, 6'h00, 1'b0, -1);
      run(0, 6'h03, 6'h00, 1'b0, -1);
      run(0, 6'h3F, 6'h00, 1'b0, -1);
      run(0, 6'h00, 6'h08, 1'b0, -1);
      run_random(0, 40);

      // Reset arriving in the MEM cycle of a store.
      run(0, 6'h2B, 6'h11, 1'b0, 3);

      // Counter wrap with a 4-bit counter.
      do_reset(0, 2);
      for (int i = 0; i < 16; i++) run(0, 6'h02, 6'h00, 1'b0, -1);
      chk("cnt_wrap", 32'(bus0.instr_cnt), 32'd0);

      // Instance with two extra fetch wait cycles.
      do_reset(1, 3);
      run(1, 6'h00, 6'h23, 1'b0, -1);
      run(1, 6'h3F, 6'h00, 1'b0, -1);
      run(1, 6'h0F, 6'h00, 1'b0, -1);
      run_random(1, 30);
      run(1, 6'h23, 6'h00, 1'b0, 4);
      run_random(1, 5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
